// File: rtl/skel_pkg.sv
// Shared types for the skeleton image path: frame geometry, pixel and
// address types, the streamed beat record and the readout FSM states.
package skel_pkg;

  localparam int SKEL_N        = 8;
  localparam int SKEL_BIT_SIZE = 6;
  localparam int SKEL_PIX_W    = 8;

  localparam int FRAME_PIXELS = SKEL_N * SKEL_N;
  localparam int ADDR_W       = SKEL_BIT_SIZE + 1;

  typedef logic [SKEL_PIX_W-1:0] pix_t;
  typedef logic [ADDR_W-1:0]     addr_t;

  typedef struct packed {
    pix_t data;
    logic sof;
    logic eol;
    logic eof;
  } pix_beat_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } rd_state_t;

endpackage

// File: rtl/stream_skid_fifo.sv
// Two-entry FIFO of tagged pixel beats. The head is held steady until it
// is popped, and a push into a full FIFO is accepted when a pop happens on
// the same edge.
module stream_skid_fifo
  import skel_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  pix_beat_t push_beat,
  input  logic      pop,
  output pix_beat_t head,
  output logic      valid,
  output logic [1:0] count
);

  pix_beat_t mem [2];
  logic      wr_ptr;
  logic      rd_ptr;
  logic      do_push;
  logic      do_pop;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);

  // Storage, pointers and occupancy update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_beat;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign valid = (count != 2'd0);

endmodule

// File: rtl/image_stream_reader.sv
// image_stream_reader: walks the image RAM in raster order through the
// dual read port after skeletonization and streams each pixel out on a
// valid/ready interface with sof/eol/eof markers.
// Build option: define STREAM_BINARIZE_EN to force every nonzero pixel to
// all-ones on the stream; otherwise raw RAM values are passed through.
module image_stream_reader
  import skel_pkg::*;
#(
  parameter int N          = SKEL_N,
  parameter int bitSize    = SKEL_BIT_SIZE,
  parameter int pixelWidth = SKEL_PIX_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  mem_hold,
  output logic                  rd_en,
  output logic [bitSize:0]      rd_address,
  input  logic [pixelWidth-1:0] rd_data,
  output logic [pixelWidth-1:0] pix_data,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic                  pix_sof,
  output logic                  pix_eol,
  output logic                  pix_eof,
  output logic                  busy,
  output logic                  done
);

  localparam int AW = bitSize + 1;
  localparam logic [bitSize:0] LAST_ADDR = AW'(N * N - 1);
  localparam logic [bitSize:0] LAST_COL  = AW'(N - 1);

`ifdef STREAM_BINARIZE_EN
  function automatic pix_t shape_pixel(input logic [pixelWidth-1:0] raw);
    return (raw != '0) ? '1 : '0;
  endfunction
`else
  function automatic pix_t shape_pixel(input logic [pixelWidth-1:0] raw);
    return pix_t'(raw);
  endfunction
`endif

  rd_state_t        state;
  rd_state_t        state_nxt;
  logic [bitSize:0] x_cnt;
  logic [bitSize:0] y_cnt;
  logic             issue;
  logic             last_issue;
  logic             hs;
  logic [2:0]       occ;
  logic [1:0]       fifo_count;
  logic             fifo_valid;
  pix_beat_t        head;
  logic             vld_p1;
  logic             sof_p1;
  logic             eol_p1;
  logic             eof_p1;
  pix_beat_t        cap_beat_p1;

  // A read is only issued if its beat is guaranteed a FIFO slot: entries
  // held after this edge's pop plus the read already in flight must leave
  // room. Counting the pop keeps full rate with pix_ready held high.
  assign hs         = fifo_valid && pix_ready;
  assign occ        = {1'b0, fifo_count} + {2'b0, vld_p1} - {2'b0, hs};
  assign issue      = (state == READ) && !mem_hold && (occ < 3'd2);
  assign last_issue = issue && (x_cnt == LAST_COL) && (y_cnt == LAST_COL);
  assign rd_en      = issue;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state; done fires on the eof handshake itself
  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = READ;
      end
      READ: begin
        if (last_issue) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (hs && head.eof) begin
          state_nxt = IDLE;
          done      = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // p0: read address and raster position advance on every issued read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_address <= '0;
      x_cnt      <= '0;
      y_cnt      <= '0;
    end else if (issue) begin
      rd_address <= (rd_address == LAST_ADDR) ? '0 : rd_address + 1'b1;
      if (x_cnt == LAST_COL) begin
        x_cnt <= '0;
        y_cnt <= (y_cnt == LAST_COL) ? '0 : y_cnt + 1'b1;
      end else begin
        x_cnt <= x_cnt + 1'b1;
      end
    end
  end

  // p1: tags of the issued address wait one cycle to meet the RAM data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      sof_p1 <= 1'b0;
      eol_p1 <= 1'b0;
      eof_p1 <= 1'b0;
    end else begin
      vld_p1 <= issue;
      if (issue) begin
        sof_p1 <= (rd_address == '0);
        eol_p1 <= (x_cnt == LAST_COL);
        eof_p1 <= (rd_address == LAST_ADDR);
      end
    end
  end

  assign cap_beat_p1 = '{data: shape_pixel(rd_data), sof: sof_p1, eol: eol_p1, eof: eof_p1};

  stream_skid_fifo u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (vld_p1),
    .push_beat (cap_beat_p1),
    .pop       (pix_ready),
    .head      (head),
    .valid     (fifo_valid),
    .count     (fifo_count)
  );

  assign pix_valid = fifo_valid;
  assign pix_data  = head.data;
  assign pix_sof   = fifo_valid && head.sof;
  assign pix_eol   = fifo_valid && head.eol;
  assign pix_eof   = fifo_valid && head.eof;

endmodule

// File: tb/tb_image_stream_reader.sv
// Bench for image_stream_reader: a RAM model feeds the read port, a frame
// model fills a scoreboard queue, and a monitor pops and compares on every
// stream handshake.
module tb_image_stream_reader;
  import skel_pkg::*;

  localparam int N  = 8;
  localparam int BS = 6;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          mem_hold = 1'b0;
  logic          pix_ready = 1'b0;
  logic          rd_en;
  logic [BS:0]   rd_address;
  logic [PW-1:0] rd_data = '0;
  logic [PW-1:0] pix_data;
  logic          pix_valid, pix_sof, pix_eol, pix_eof, busy, done;

  image_stream_reader #(.N(N), .bitSize(BS), .pixelWidth(PW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mem_hold(mem_hold),
    .rd_en(rd_en), .rd_address(rd_address), .rd_data(rd_data),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_eof(pix_eof),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  pix_t ram [0:(1<<ADDR_W)-1];
  always @(posedge clk) if (rd_en) rd_data <= ram[rd_address];

  int tests_run = 0;
  int fails = 0;
  int cyc = 0;
  int beats = 0;
  int done_cnt = 0;
  int first_valid = -1;
  int first_rden = -1;
  int ready_mode = 0;
  int hold_mode = 0;
  int phase = 0;
  pix_beat_t exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  function automatic pix_t model_pixel(input pix_t v);
`ifdef STREAM_BINARIZE_EN
    return (v != '0) ? {PW{1'b1}} : '0;
`else
    return v;
`endif
  endfunction

  // Expected frame: pixel i in raster order, markers from its position
  task automatic push_frame();
    for (int i = 0; i < FRAME_PIXELS; i++) begin
      pix_beat_t b;
      b.data = model_pixel(ram[i]);
      b.sof  = (i == 0);
      b.eol  = ((i % N) == N - 1);
      b.eof  = (i == FRAME_PIXELS - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic fill_ram(input int kind);
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      case (kind)
        0: ram[i] = pix_t'(i);
        1: ram[i] = pix_t'($urandom_range(0, 255));
        default: case (i % 4)
          1: ram[i] = 8'd5;
          3: ram[i] = 8'd255;
          default: ram[i] = 8'd0;
        endcase
      endcase
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " rd_en"}, rd_en, 0);
    check({tag, " rd_address"}, rd_address, 0);
    check({tag, " pix_valid"}, pix_valid, 0);
    check({tag, " pix_data"}, pix_data, 0);
    check({tag, " markers"}, {pix_sof, pix_eol, pix_eof}, 0);
    check({tag, " busy"}, busy, 0);
    check({tag, " done"}, done, 0);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk); #1;
      if (done) seen = 1;
    end
    if (!seen) begin
      tests_run++;
      fails++;
      $display("FAIL done_timeout: no done within %0d cycles, queue holds %0d", budget, exp_q.size());
    end
  endtask

  task automatic wait_beats(input int target, input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk); #1;
      if (beats >= target) seen = 1;
    end
    if (!seen) begin
      tests_run++;
      fails++;
      $display("FAIL beat_timeout: got %0d beats, required %0d", beats, target);
    end
  endtask

  // Cycle counter
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Downstream ready and port-arbitration drivers
  initial forever begin
    @(posedge clk); #1;
    phase++;
    case (ready_mode)
      0: pix_ready = 1'b1;
      1: pix_ready = ((phase % 4) == 0) || ((phase % 4) == 3);
      default: pix_ready = ($urandom_range(0, 1) == 1);
    endcase
    if (hold_mode == 1) mem_hold = ($urandom_range(0, 3) == 0);
  end

  // Monitor: scoreboard pop on each handshake, stall stability, hold rule
  initial begin
    logic        stall_prev;
    logic [10:0] held;
    pix_beat_t   e;
    stall_prev = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          check("stall valid", pix_valid, 1);
          check("stall beat", {pix_data, pix_sof, pix_eol, pix_eof}, held);
        end
        if (mem_hold) check("hold rd_en", rd_en, 0);
        if (rd_en && first_rden < 0) first_rden = cyc;
        if (pix_valid && first_valid < 0) first_valid = cyc;
        if (pix_valid && pix_ready) begin
          if (exp_q.size() == 0) begin
            tests_run++;
            fails++;
            $display("FAIL extra beat: got data %0d, required no beat", pix_data);
          end else begin
            e = exp_q.pop_front();
            check("beat data", pix_data, e.data);
            check("beat sof", pix_sof, e.sof);
            check("beat eol", pix_eol, e.eol);
            check("beat eof", pix_eof, e.eof);
            check("beat done", done, e.eof);
          end
          beats++;
        end else begin
          check("done without eof", done, 0);
        end
        if (done) done_cnt++;
        stall_prev = pix_valid && !pix_ready;
        held = {pix_data, pix_sof, pix_eol, pix_eof};
      end
    end
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d beats seen", beats);
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int d0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1 rst_n = 1'b1;

    // Full-speed ramp frame: latency, throughput and frame length
    fill_ram(0);
    ready_mode = 0;
    push_frame();
    repeat (2) @(posedge clk);
    #1;
    first_valid = -1;
    first_rden = -1;
    start = 1'b1;
    s = cyc;
    @(negedge clk);
    check("busy before accept", busy, 0);
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("busy after accept", busy, 1);
    wait_done(200);
    check("rd_en latency", first_rden - s, 1);
    check("pix_valid latency", first_valid - s, 3);
    check("frame cycles", cyc - s + 1, FRAME_PIXELS + 3);
    check("queue drained", exp_q.size(), 0);
    @(negedge clk);
    check("busy after done", busy, 0);

    // Backpressure 1,0,0,1
    ready_mode = 1;
    push_frame();
    pulse_start();
    wait_done(600);
    check("backpressure drained", exp_q.size(), 0);

    // mem_hold for cycles 10..19 after start
    ready_mode = 0;
    fill_ram(1);
    push_frame();
    @(posedge clk); #1 start = 1'b1;
    s = cyc;
    for (int k = 1; k <= 25; k++) begin
      @(posedge clk); #1;
      if (k == 1) start = 1'b0;
      mem_hold = (k >= 10 && k <= 19);
    end
    mem_hold = 1'b0;
    wait_done(200);
    check("hold frame cycles", cyc - s + 1, FRAME_PIXELS + 3 + 10);
    check("hold drained", exp_q.size(), 0);

    // Reset after beat 20, then restream from pixel 0
    ready_mode = 2;
    fill_ram(1);
    push_frame();
    d0 = beats;
    pulse_start();
    wait_beats(d0 + 21, 400);
    @(posedge clk); #1 rst_n = 1'b0;
    d0 = done_cnt;
    @(negedge clk);
    check_idle_outputs("abort");
    exp_q.delete();
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    check("abort no done", done_cnt, d0);
    ready_mode = 0;
    push_frame();
    pulse_start();
    wait_done(200);
    check("restream drained", exp_q.size(), 0);

    // Start while busy is ignored; start right after done is accepted
    ready_mode = 2;
    hold_mode = 1;
    fill_ram(1);
    push_frame();
    d0 = done_cnt;
    s = beats;
    pulse_start();
    wait_beats(s + 30, 400);
    pulse_start();
    wait_done(800);
    check("single done", done_cnt, d0 + 1);
    check("busy frame drained", exp_q.size(), 0);
    push_frame();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("back-to-back busy", busy, 1);
    wait_done(800);
    check("back-to-back done", done_cnt, d0 + 2);
    hold_mode = 0;
    mem_hold = 1'b0;

    // Binarize pattern 0,5,0,255
    ready_mode = 0;
    fill_ram(2);
    push_frame();
    pulse_start();
    wait_done(200);

    // Random frames under random ready and hold
    ready_mode = 2;
    hold_mode = 1;
    for (int f = 0; f < 3; f++) begin
      fill_ram(1);
      push_frame();
      pulse_start();
      wait_done(1000);
    end
    hold_mode = 0;
    mem_hold = 1'b0;

    repeat (5) @(posedge clk);
    check("final queue empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
